// File: rtl/gray_convert_arbiter.sv
// Round-robin arbiter sharing one Gray-to-binary converter among N_REQ
// requesters, with a one-entry registered result and a conversion counter.
module gray_convert_arbiter #(
    parameter int WIDTH = 4,
    parameter int N_REQ = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*WIDTH-1:0]   req_gray,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_bin,
    output logic [$clog2(N_REQ)-1:0] out_id,
    input  logic                     out_ready,
    output logic [CNT_W-1:0]         conv_count
);

    localparam int IDW = $clog2(N_REQ);

    typedef enum logic {
        EMPTY,
        FULL
    } state_e;

    state_e           state_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_bin_q;
    logic [IDW-1:0]   out_id_q;
    logic [IDW-1:0]   rr_ptr_q;
    logic [CNT_W-1:0] cnt_q;

    logic [N_REQ-1:0] rot;
    logic [IDW-1:0]   off;
    logic [IDW:0]     sum;
    logic [IDW-1:0]   grant;
    logic             any_v;
    logic [WIDTH-1:0] gsel;
    logic [WIDTH-1:0] bin_d;
    logic [IDW-1:0]   rr_ptr_d;
    logic             can_accept;
    logic             accept;

    function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = '0;
        b[WIDTH-1] = g[WIDTH-1];
        for (int k = WIDTH - 2; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        return b;
    endfunction

    // Rotate so that bit 0 is the requester at rr_ptr, then find first set.
    always_comb begin
        rot   = N_REQ'({req_valid, req_valid} >> rr_ptr_q);
        off   = '0;
        any_v = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off   = IDW'(k);
                any_v = 1'b1;
            end
        end
        sum   = {1'b0, rr_ptr_q} + {1'b0, off};
        grant = (sum >= (IDW+1)'(N_REQ)) ? IDW'(sum - (IDW+1)'(N_REQ))
                                         : sum[IDW-1:0];
    end

    always_comb begin
        gsel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (IDW'(i) == grant) gsel = req_gray[i*WIDTH +: WIDTH];
        end
        bin_d = g2b(gsel);
    end

    assign can_accept = (state_q == EMPTY) | out_ready;
    assign accept     = rst_n & any_v & can_accept;
    assign rr_ptr_d   = (grant == IDW'(N_REQ - 1)) ? '0 : grant + IDW'(1);

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = accept & (IDW'(i) == grant);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            out_bin_q   <= '0;
            out_id_q    <= '0;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            if (accept) begin
                // A pop in the same cycle is absorbed: new result replaces old.
                state_q     <= FULL;
                out_valid_q <= 1'b1;
                out_bin_q   <= bin_d;
                out_id_q    <= grant;
                rr_ptr_q    <= rr_ptr_d;
                cnt_q       <= cnt_q + CNT_W'(1);
            end else if (state_q == FULL && out_ready) begin
                state_q     <= EMPTY;
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_bin    = out_bin_q;
    assign out_id     = out_id_q;
    assign conv_count = cnt_q;

endmodule

// File: tb/tb_gray_convert_arbiter.sv
// Directed bench for gray_convert_arbiter: reference model plus scoreboard
// of expected {id, bin} results, checked with immediate assertions.
module tb_gray_convert_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [15:0] req_gray;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [3:0]  out_bin;
    logic [1:0]  out_id;
    logic        out_ready;
    logic [15:0] conv_count;

    gray_convert_arbiter #(.WIDTH(4), .N_REQ(4), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_gray   (req_gray),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_bin    (out_bin),
        .out_id     (out_id),
        .out_ready  (out_ready),
        .conv_count (conv_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [3:0] bin;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   m_rr;
    bit   m_full;
    int   m_cnt;

    function automatic logic [3:0] g2b_ref(input logic [3:0] g);
        logic [3:0] b;
        for (int k = 0; k < 4; k++) b[k] = ^(g >> k);
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rr   = 0;
        m_full = 0;
        m_cnt  = 0;
        sb.delete();
    endtask

    // Inputs are already driven; check comb outputs, advance one edge.
    task automatic step();
        int         g;
        bit         anyv;
        bit         can;
        logic [3:0] er;
        exp_t       e;
        #2;
        g    = 0;
        anyv = 0;
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (m_rr + k) % 4;
            if (!anyv && req_valid[i]) begin
                g    = i;
                anyv = 1;
            end
        end
        can = !m_full || out_ready;
        er  = (anyv && can) ? 4'(1 << g) : 4'b0;
        chk("req_ready", req_ready, er);
        chk("out_valid", out_valid, m_full);
        if (m_full && out_ready) begin
            chk("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_bin", out_bin, e.bin);
                chk("sb_id", out_id, e.id);
            end
        end
        if (anyv && can) begin
            e.id  = g;
            e.bin = g2b_ref(req_gray[g*4 +: 4]);
            sb.push_back(e);
            m_rr   = (g + 1) % 4;
            m_cnt  = (m_cnt + 1) % 65536;
            m_full = 1;
        end else if (out_ready) begin
            m_full = 0;
        end
        @(posedge clk);
        #1;
        chk("conv_count", conv_count, m_cnt);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [3:0] snap_bin;
        logic [1:0] snap_id;
        logic [3:0] gw;

        rst_n     = 1'b0;
        req_valid = '0;
        req_gray  = '0;
        out_ready = 1'b0;
        model_reset();
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_bin", out_bin, 0);
        chk("rst_out_id", out_id, 0);
        chk("rst_conv_count", conv_count, 0);
        chk("rst_req_ready", req_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single request from requester 2
        req_valid       = 4'b0100;
        req_gray[11:8]  = 4'b1101;
        out_ready       = 1'b1;
        step();
        chk("single_valid", out_valid, 1);
        chk("single_bin", out_bin, 4'b1001);
        chk("single_id", out_id, 2);
        chk("single_cnt", conv_count, 1);
        req_valid = '0;
        step();

        // Async reset while a result is held
        req_valid = 4'b0001;
        req_gray  = 16'h0003;
        step();
        chk("pre_rst_valid", out_valid, 1);
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_bin", out_bin, 0);
        chk("arst_conv_count", conv_count, 0);
        chk("arst_req_ready", req_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();

        // Fairness: all requesters valid
        req_gray  = 16'h7C3A;
        req_valid = 4'hF;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("fair_id", out_id, i % 4);
        end
        chk("fair_cnt", conv_count, 8);

        // Backpressure: hold output, no grants
        out_ready = 1'b0;
        snap_bin  = out_bin;
        snap_id   = out_id;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_bin", out_bin, snap_bin);
            chk("bp_id", out_id, snap_id);
        end
        out_ready = 1'b1;
        step();
        chk("bp_next_id", out_id, (snap_id + 1) % 4);
        step();
        step();
        req_valid = '0;
        step();

        // Exhaustive conversion via requester 3
        req_valid = 4'b1000;
        for (int b = 0; b < 16; b++) begin
            gw              = 4'(b ^ (b >> 1));
            req_gray[15:12] = gw;
            step();
            chk("conv_b", out_bin, b);
        end
        req_valid = '0;
        step();

        // Counter and pointer wrap
        do_reset();
        req_gray  = 16'hA5C3;
        req_valid = 4'hF;
        out_ready = 1'b1;
        for (int i = 0; i < 65535; i++) step();
        chk("cnt_max", conv_count, 16'hFFFF);
        step();
        chk("cnt_wrap", conv_count, 0);
        chk("wrap_id3", out_id, 3);
        step();
        chk("wrap_id0", out_id, 0);
        req_valid = '0;
        step();
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
